// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// flattened-port slicing helpers and the per-register scoreboard state.
package regfile_pkg;

    localparam int unsigned ZERO_ADDR = 0;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } busy_state_e;

    // Smallest width that can index `value` entries; callers guarantee value >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // LSB of port `port` inside a flattened bus of `width`-bit fields.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: flush beats issue (set), issue beats writeback (clear).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = clog2(NUM_REGS),
    parameter int unsigned NUM_WR   = 1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     sb_set_i,
    input  logic [ADDR_W-1:0]        sb_addr_i,
    input  logic                     flush_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    output logic [NUM_REGS-1:0]      busy_o
);

    busy_state_e busy_q [NUM_REGS];
    busy_state_e busy_d [NUM_REGS];

    logic [NUM_REGS-1:0] set_hit;
    logic [NUM_REGS-1:0] clr_hit;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    always_comb begin
        set_hit = '0;
        clr_hit = '0;
        if (sb_set_i && !(ZERO_REG && sb_addr_i == ADDR_W'(ZERO_ADDR))) begin
            set_hit[sb_addr_i] = 1'b1;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j]) begin
                clr_hit[wr_addr_i[port_lsb(j, ADDR_W) +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r];
            if (flush_i) begin
                busy_d[r] = SB_IDLE;
            end else begin
                case (busy_q[r])
                    SB_IDLE: if (set_hit[r]) busy_d[r] = SB_BUSY;
                    // A re-issue in the same cycle as the old producer's
                    // writeback keeps the register owned by the new producer.
                    SB_BUSY: if (!set_hit[r] && clr_hit[r]) busy_d[r] = SB_IDLE;
                    default: busy_d[r] = SB_IDLE;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= SB_IDLE;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

    always_comb begin
        busy_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_o[r] = (busy_q[r] == SB_BUSY);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, NUM_WR write
// ports (highest index wins), optional write-to-read bypass and zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned NUM_WR   = 1,
    parameter  bit          BYPASS   = 1'b1,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     flush
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    function automatic logic [ADDR_W-1:0] rd_addr_at(input int unsigned k);
        return rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] wr_addr_at(input int unsigned j);
        return wr_addr[port_lsb(j, ADDR_W) +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] wr_data_at(input int unsigned j);
        return wr_data[port_lsb(j, DATA_W) +: DATA_W];
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
    endfunction

    // Later ports overwrite earlier ones, so port NUM_WR-1 wins on a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && !is_zero_reg(wr_addr_at(j))) begin
                regs_d[wr_addr_at(j)] = wr_data_at(j);
            end
        end
    end

    // NOTE: the array is cleared by the asynchronous reset, which forces it into
    // flops; a RAM macro could not be zeroed without clock edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .sb_set_i  (sb_set),
        .sb_addr_i (sb_addr),
        .flush_i   (flush),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .busy_o    (busy)
    );

    // RST gates the outputs directly: stored state is already clear, but the
    // bypass path would otherwise forward write data while reset is held.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!RST) begin
                rd_data[port_lsb(k, DATA_W) +: DATA_W] = regs_q[rd_addr_at(k)];
                if (BYPASS) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && wr_addr_at(j) == rd_addr_at(k)) begin
                            rd_data[port_lsb(k, DATA_W) +: DATA_W] = wr_data_at(j);
                        end
                    end
                end
                if (is_zero_reg(rd_addr_at(k))) begin
                    rd_data[port_lsb(k, DATA_W) +: DATA_W] = '0;
                end
                rd_busy[k] = busy[rd_addr_at(k)];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two 32x32 files (bypass+zero-reg / no-bypass, no zero-reg)
// compared every cycle against a behavioural model, plus a 16x64 four-read file.
module tb_regfile_mp;

    logic        CLK;
    logic        RST;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        flush;

    logic [15:0]  rd_addr_c;
    logic [255:0] rd_data_c;
    logic [3:0]   rd_busy_c;
    logic [1:0]   wr_en_c;
    logic [7:0]   wr_addr_c;
    logic [127:0] wr_data_c;
    logic         sb_set_c;
    logic [3:0]   sb_addr_c;
    logic         flush_c;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    regfile_mp #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
    );

    regfile_mp #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush)
    );

    regfile_mp #(
        .DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_c (
        .CLK(CLK), .RST(RST), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
        .sb_set(sb_set_c), .sb_addr(sb_addr_c), .flush(flush_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (config 0 = dut_a, 1 = dut_b) -------
    logic [31:0] m_reg  [2][32];
    logic        m_busy [2][32];

    function automatic bit zero_cfg(input int c);
        return c == 0;
    endfunction

    function automatic bit bypass_cfg(input int c);
        return c == 0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 32; i++) begin
                    m_reg[c][i]  <= '0;
                    m_busy[c][i] <= 1'b0;
                end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < 2; j++) begin
                    if (wr_en[j] && !(zero_cfg(c) && wr_addr[j*5 +: 5] == 5'd0)) begin
                        m_reg[c][wr_addr[j*5 +: 5]]  <= wr_data[j*32 +: 32];
                        m_busy[c][wr_addr[j*5 +: 5]] <= 1'b0;
                    end
                end
                if (sb_set && !(zero_cfg(c) && sb_addr == 5'd0))
                    m_busy[c][sb_addr] <= 1'b1;
                if (flush)
                    for (int i = 0; i < 32; i++) m_busy[c][i] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
        if (RST) return '0;
        if (zero_cfg(c) && a == 5'd0) return '0;
        if (bypass_cfg(c)) begin
            if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
            if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
        end
        return m_reg[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [4:0] a);
        if (RST) return 1'b0;
        if (zero_cfg(c) && a == 5'd0) return 1'b0;
        return m_busy[c][a];
    endfunction

    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("a_data%0d", k), rd_data_a[k*32 +: 32], exp_data(0, rd_addr[k*5 +: 5]));
                check($sformatf("a_busy%0d", k), rd_busy_a[k], exp_busy(0, rd_addr[k*5 +: 5]));
                check($sformatf("b_data%0d", k), rd_data_b[k*32 +: 32], exp_data(1, rd_addr[k*5 +: 5]));
                check($sformatf("b_busy%0d", k), rd_busy_b[k], exp_busy(1, rd_addr[k*5 +: 5]));
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
        flush   = 1'b0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wr_en[j]          = 1'b1;
        wr_addr[j*5 +: 5] = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic issue(input logic [4:0] a);
        sb_set  = 1'b1;
        sb_addr = a;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        rd_addr   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_c = '0;
        wr_en_c   = '0;
        wr_addr_c = '0;
        wr_data_c = '0;
        sb_set_c  = 1'b0;
        sb_addr_c = '0;
        flush_c   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        rd(0, 5'd3); rd(1, 5'd9);
        #1;
        check("reset_data_a", rd_data_a, 64'd0);
        check("reset_busy_a", rd_busy_a, 64'd0);

        // Write r3 with and without bypass
        wr(0, 5'd3, 32'h1234_5678);
        #1;
        check("bypass_same_cycle", rd_data_a[31:0], 32'h1234_5678);
        check("nobypass_old", rd_data_b[31:0], 32'h0);
        tick(); idle();
        #1;
        check("nobypass_next", rd_data_b[31:0], 32'h1234_5678);

        // Zero register: write and issue to r0
        wr(0, 5'd0, 32'hFFFF_FFFF); issue(5'd0); rd(0, 5'd0);
        #1;
        check("zero_bypass_a", rd_data_a[31:0], 32'h0);
        tick(); idle();
        #1;
        check("zero_data_a", rd_data_a[31:0], 32'h0);
        check("zero_busy_a", rd_busy_a[0], 1'b0);
        check("r0_data_b", rd_data_b[31:0], 32'hFFFF_FFFF);
        check("r0_busy_b", rd_busy_b[0], 1'b1);

        // Dual write conflict on r7
        wr(0, 5'd7, 32'hAA); wr(1, 5'd7, 32'hBB); rd(0, 5'd7);
        #1;
        check("dual_bypass_a", rd_data_a[31:0], 32'hBB);
        tick(); idle();
        #1;
        check("dual_a", rd_data_a[31:0], 32'hBB);
        check("dual_b", rd_data_b[31:0], 32'hBB);

        // Scoreboard on r9
        issue(5'd9); rd(1, 5'd9);
        #1;
        check("busy_latency", rd_busy_a[1], 1'b0);
        tick(); idle();
        #1;
        check("busy_set", rd_busy_a[1], 1'b1);
        wr(0, 5'd9, 32'h99);
        #1;
        check("busy_not_hidden", rd_busy_a[1], 1'b1);
        check("busy_bypass_data", rd_data_a[63:32], 32'h99);
        tick(); idle();
        #1;
        check("busy_cleared", rd_busy_a[1], 1'b0);
        issue(5'd9); wr(0, 5'd9, 32'h1234_0009);
        tick(); idle();
        #1;
        check("set_beats_clear", rd_busy_a[1], 1'b1);
        check("set_clear_data", rd_data_a[63:32], 32'h1234_0009);

        // Flush
        issue(5'd1); tick();
        issue(5'd2); tick();
        issue(5'd4); tick(); idle();
        rd(0, 5'd1); rd(1, 5'd4);
        #1;
        check("pre_flush_busy", rd_busy_a, 64'h3);
        flush = 1'b1; issue(5'd6);
        tick(); idle();
        rd(0, 5'd6); rd(1, 5'd9);
        #1;
        check("flush_r6", rd_busy_a[0], 1'b0);
        check("flush_r9", rd_busy_a[1], 1'b0);
        rd(0, 5'd3); rd(1, 5'd4);
        #1;
        check("flush_r4", rd_busy_a[1], 1'b0);
        check("flush_keeps_data", rd_data_a[31:0], 32'h1234_5678);
        tick();

        // Asynchronous reset mid-run
        wr(0, 5'd5, 32'hDEAD_BEEF); issue(5'd5);
        tick(); idle();
        rd(0, 5'd5); rd(1, 5'd9);
        #1;
        check("pre_rst_data", rd_data_a[31:0], 32'hDEAD_BEEF);
        check("pre_rst_busy", rd_busy_a[0], 1'b1);
        #1;
        RST = 1'b1;
        wr(0, 5'd5, 32'h5555_5555);
        #1;
        check("rst_data_a0", rd_data_a[31:0], 32'h0);
        check("rst_data_a1", rd_data_a[63:32], 32'h0);
        check("rst_busy_a", rd_busy_a, 64'h0);
        check("rst_data_b", rd_data_b, 64'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("post_rst_cleared_b", rd_data_b[31:0], 32'h0);
        check("post_rst_bypass_a", rd_data_a[31:0], 32'h5555_5555);
        tick(); idle();
        #1;
        check("first_write_after_rst", rd_data_b[31:0], 32'h5555_5555);

        // Wide four-read configuration
        wr_en_c   = 2'b11;
        wr_addr_c = {4'd13, 4'd12};
        wr_data_c = {64'd1, 64'd0};
        tick();
        wr_addr_c = {4'd15, 4'd14};
        wr_data_c = {64'd3, 64'd2};
        tick();
        wr_en_c   = '0;
        rd_addr_c = {4'd15, 4'd14, 4'd13, 4'd12};
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("c_rd%0d", k), rd_data_c[k*64 +: 64], 64'(k));
        check("c_busy_idle", rd_busy_c, 64'h0);
        wr_en_c   = 2'b01;
        wr_addr_c = {4'd0, 4'd12};
        wr_data_c = {64'd0, 64'hCAFE_F00D_0000_0001};
        sb_set_c  = 1'b1;
        sb_addr_c = 4'd13;
        #1;
        check("c_bypass", rd_data_c[63:0], 64'hCAFE_F00D_0000_0001);
        tick();
        wr_en_c  = '0;
        sb_set_c = 1'b0;
        #1;
        check("c_busy_r13", rd_busy_c, 64'h2);
        check("c_stored", rd_data_c[63:0], 64'hCAFE_F00D_0000_0001);

        tick();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU datapath, replacing the fixed 32×32, two-read/one-write file of the single-cycle core. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional same-cycle write-to-read bypass and an optional hardwired zero register. An integrated scoreboard keeps one busy bit per register so issue logic can detect pending writes.

## Interface
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: register count; power of two, ≥2.
- ADDR_W, $clog2(NUM_REGS): address width; derived, not overridden.
- NUM_RD, 2: read ports, 1–4.
- NUM_WR, 1: write ports, 1–2.
- BYPASS, 1: 1 = read returns same-cycle write data; 0 = read returns stored value.
- ZERO_REG, 1: 1 = register 0 reads 0, and writes and busy-sets to it are ignored.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy bit of each addressed register, before bypass.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- sb_set  in  1  mark register sb_addr busy; asserted when an instruction issues.
- sb_addr  in  ADDR_W  destination register being issued.
- flush  in  1  clear all busy bits on a pipeline flush; register contents are kept.

## Operation
- Reset: all registers 0 and all busy bits 0. While RST is high, every rd_data field reads 0 and every rd_busy bit is 0.
- Write: when wr_en[j] is high, register wr_addr[j] takes wr_data[j] at the clock edge. If both write ports target the same address in one cycle, port NUM_WR-1 wins.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - rd_data for address 0 is always 0, including under bypass.
  - rd_busy for address 0 is always 0.
- Read: rd_data[k] is combinational from rd_addr[k].
  - BYPASS=1 and an enabled write matches the address: output that write's data, with the same port-priority rule.
  - Otherwise: output the stored register value.
- Scoreboard (per register busy bit), in priority order at each edge:
  1. flush: all bits clear.
  2. sb_set: bit sb_addr set. If a write to the same address happens in the same cycle, set wins, because the new producer supersedes the old one.
  3. Enabled write: bit wr_addr[j] clears.
- Busy-state transitions: idle→busy on sb_set; busy→idle on write or flush; busy→busy on sb_set while busy (re-issue). A write to a register that is not busy is legal and leaves the bit clear.
- rd_busy reflects the registered bit. A same-cycle write does not hide busy; the issue stage combines rd_busy with bypass knowledge.

## Timing
- Read latency 0 cycles, combinational from rd_addr, wr_*, and state.
- Write latency 1 cycle: visible without bypass on the cycle after wr_en.
- Busy set/clear latency 1 cycle.
- Reset asserted mid-operation: contents and busy bits clear immediately, with no clock edge needed. The first write is accepted on the first rising edge after RST falls.

## Structure
- Shared package regfile_pkg holds:
  - function clog2 (address width);
  - helper functions to slice the flattened ports by port index;
  - constant ZERO_ADDR.
- Sub-module regfile_scoreboard: NUM_REGS busy bits with the flush/set/clear priority above. Instantiated once; the storage array and read muxes stay in regfile_mp.

## Test plan
- Reset: drive RST=1 mid-run after writing 0xDEADBEEF to r5 → rd_data for r5 is 0 and all rd_busy are 0, with no clock edge.
- Write/read and bypass:
  - Write r3=0x12345678 with BYPASS=1 → rd_addr=3 reads 0x12345678 in the same cycle.
  - Same write with BYPASS=0 → old value this cycle, 0x12345678 next cycle.
- Zero register and write conflict:
  - With ZERO_REG=1, write r0=0xFFFFFFFF and sb_set r0 → r0 reads 0 and is not busy.
  - Dual write to r7 with port0=0xAA and port1=0xBB → r7 = 0xBB.
- Scoreboard: sb_set r9 → rd_busy=1 on the next cycle. Write r9 → busy clears. sb_set r9 and write r9 in the same cycle → busy stays 1 and r9 holds the new data.
- Flush: set r1, r2, r4 busy, then assert flush together with sb_set r6 → all busy bits 0, including r6; register data unchanged.
- Parametric: NUM_REGS=16, DATA_W=64, NUM_RD=4 → all four ports read distinct written values 0x0..0x3 from r12–r15 concurrently.
